// File: rtl/chan_cfg_pkg.sv
// Shared types and constants for the channel configuration sequencer.
// Pure declarations: no logic, no latency.
// No flow control lives here; see chan_cfg_sequencer for handshake behaviour.
package chan_cfg_pkg;

  // Width of the outstanding-frame counter (saturates at 2**CNT_W-1)
  localparam int CNT_W = 4;

  // Power-on configuration
  localparam logic [11:0] CFG_DEF_FFT_SIZE = 12'd256;
  localparam logic [8:0]  CFG_DEF_AVG_LEN  = 9'd16;

  // Sequencer states
  localparam logic [2:0] ST_RUN      = 3'd0;
  localparam logic [2:0] ST_WAIT_EOF = 3'd1;
  localparam logic [2:0] ST_DRAIN    = 3'd2;
  localparam logic [2:0] ST_RESET    = 3'd3;
  localparam logic [2:0] ST_SETTLE   = 3'd4;

  typedef struct packed {
    logic [11:0] fft_size;
    logic [8:0]  avg_len;
  } chan_cfg_t;

  // Legal configuration: fft_size a power of two in 8..2048, avg_len nonzero
  function automatic logic cfg_is_legal(input logic [11:0] fft, input logic [8:0] avg);
    logic pow2;
    pow2 = (fft != 12'd0) && ((fft & (fft - 12'd1)) == 12'd0);
    return pow2 && (fft >= 12'd8) && (fft <= 12'd2048) && (avg != 9'd0);
  endfunction

endpackage

// File: rtl/chan_cfg_sequencer_if.sv
// Bundles the config handshake, the upstream/datapath streams and the monitored datapath output.
// Wires only: no latency.
// slave = sequencer side; master = the environment driving config and streams.
interface chan_cfg_sequencer_if;
  logic        cfg_valid;
  logic [11:0] cfg_fft_size;
  logic [8:0]  cfg_avg_len;
  logic        cfg_ready;
  logic        up_tvalid;
  logic        up_tlast;
  logic        up_tready;
  logic        dp_tvalid;
  logic        dp_tready;
  logic        dn_tvalid;
  logic        dn_tready;
  logic        dn_tlast;

  modport slave (
    input  cfg_valid, cfg_fft_size, cfg_avg_len,
    input  up_tvalid, up_tlast, dp_tready,
    input  dn_tvalid, dn_tready, dn_tlast,
    output cfg_ready, up_tready, dp_tvalid
  );

  modport master (
    output cfg_valid, cfg_fft_size, cfg_avg_len,
    output up_tvalid, up_tlast, dp_tready,
    output dn_tvalid, dn_tready, dn_tlast,
    input  cfg_ready, up_tready, dp_tvalid
  );
endinterface

// File: rtl/chan_cfg_frame_tracker.sv
// Tracks whether an input frame is half-sent and how many frames are still inside the datapath.
// State updates one cycle after the beat; frame_open/drained look ahead at this cycle's events.
// Observes handshakes only, never stalls either stream.
module chan_cfg_frame_tracker
  import chan_cfg_pkg::*;
(
  input  logic clk,
  input  logic sync_reset,
  input  logic in_beat,     // accepted upstream beat
  input  logic in_last,     // tlast of that beat
  input  logic out_last,    // datapath output tlast handshake
  output logic in_frame,
  output logic frame_open,  // in_frame as it will be after this cycle
  output logic drained      // outstanding count will be zero after this cycle
);

  logic [CNT_W-1:0] frame_cnt;
  logic [CNT_W-1:0] cnt_nxt;
  logic             in_eof;

  assign in_eof     = in_beat & in_last;
  assign frame_open = in_beat ? ~in_last : in_frame;
  assign drained    = (cnt_nxt == '0);

  // Saturating up/down count; coincident in/out tlast cancel out
  always_comb begin
    cnt_nxt = frame_cnt;
    if (in_eof && !out_last) begin
      if (frame_cnt != '1) cnt_nxt = frame_cnt + 1'b1;
    end else if (!in_eof && out_last) begin
      if (frame_cnt != '0) cnt_nxt = frame_cnt - 1'b1;
    end
  end

  // Register frame position and outstanding count
  always_ff @(posedge clk) begin
    if (sync_reset) begin
      in_frame  <= 1'b0;
      frame_cnt <= '0;
    end else begin
      if (in_beat) in_frame <= ~in_last;
      frame_cnt <= cnt_nxt;
    end
  end

endmodule

// File: rtl/chan_cfg_sequencer.sv
// Applies a new FFT/averaging config safely: finish frame, drain datapath, pulse dp_reset, settle.
// cfg accepted in 1 cycle in RUN; new values appear when the datapath has drained.
// Upstream stalled (up_tready=0) from end of current frame until settle completes. Option: CHAN_CFG_SEQUENCER_VALIDATE_EN.
module chan_cfg_sequencer
  import chan_cfg_pkg::*;
#(
  parameter logic [11:0] DEF_FFT_SIZE  = CFG_DEF_FFT_SIZE,
  parameter logic [8:0]  DEF_AVG_LEN   = CFG_DEF_AVG_LEN,
  parameter int          RST_CYCLES    = 4,
  parameter int          SETTLE_CYCLES = 24
) (
  input  logic                 clk,
  input  logic                 sync_reset,
  chan_cfg_sequencer_if.slave  bus,
  output logic [11:0]          fft_size,
  output logic [8:0]           avg_len,
  output logic                 dp_reset,
  output logic                 busy,
  output logic                 cfg_err
);

  localparam logic [5:0] RST_LAST    = 6'(RST_CYCLES - 1);
  localparam logic [5:0] SETTLE_LAST = 6'(SETTLE_CYCLES - 1);

  logic [2:0] state, state_nxt;
  logic [5:0] timer;
  chan_cfg_t  shadow;
  logic       pass, in_beat, out_last, cfg_acc, cfg_ok;
  logic       in_frame, frame_open, drained;

  // Data flows in RUN and while finishing the current frame in WAIT_EOF
  assign pass          = (state == ST_RUN) || (state == ST_WAIT_EOF);
  assign bus.dp_tvalid = pass & bus.up_tvalid;
  assign bus.up_tready = pass & bus.dp_tready;
  assign bus.cfg_ready = (state == ST_RUN);
  assign dp_reset      = (state == ST_RESET);
  assign busy          = (state != ST_RUN);

  assign in_beat  = bus.up_tvalid & bus.up_tready;
  assign out_last = bus.dn_tvalid & bus.dn_tready & bus.dn_tlast;
  assign cfg_acc  = bus.cfg_valid & bus.cfg_ready;

`ifdef CHAN_CFG_SEQUENCER_VALIDATE_EN
  assign cfg_ok = cfg_is_legal(bus.cfg_fft_size, bus.cfg_avg_len);

  // One-cycle error pulse for a rejected config
  always_ff @(posedge clk) begin
    if (sync_reset) cfg_err <= 1'b0;
    else            cfg_err <= cfg_acc & ~cfg_ok;
  end
`else
  assign cfg_ok  = 1'b1;
  assign cfg_err = 1'b0;
`endif

  chan_cfg_frame_tracker u_tracker (
    .clk        (clk),
    .sync_reset (sync_reset),
    .in_beat    (in_beat),
    .in_last    (bus.up_tlast),
    .out_last   (out_last),
    .in_frame   (in_frame),
    .frame_open (frame_open),
    .drained    (drained)
  );

  // Next-state logic. frame_open (not the registered in_frame) decides WAIT_EOF so that a
  // first beat accepted alongside the config is not cut off, and a last beat alongside it
  // skips WAIT_EOF.
  always_comb begin
    state_nxt = state;
    case (state)
      ST_RUN:      if (cfg_acc && cfg_ok) state_nxt = frame_open ? ST_WAIT_EOF : ST_DRAIN;
      ST_WAIT_EOF: if (in_beat && bus.up_tlast) state_nxt = ST_DRAIN;
      ST_DRAIN:    if (drained) state_nxt = ST_RESET;
      ST_RESET:    if (timer == RST_LAST) state_nxt = ST_SETTLE;
      ST_SETTLE:   if (timer == SETTLE_LAST) state_nxt = ST_RUN;
      default:     state_nxt = ST_RUN;
    endcase
  end

  // State register and per-state cycle timer (restarts on every transition)
  always_ff @(posedge clk) begin
    if (sync_reset) begin
      state <= ST_RUN;
      timer <= '0;
    end else begin
      state <= state_nxt;
      if (state_nxt != state)                             timer <= '0;
      else if (state == ST_RESET || state == ST_SETTLE)   timer <= timer + 1'b1;
    end
  end

  // Shadow capture on accept; live config updates only on the DRAIN->RESET edge
  always_ff @(posedge clk) begin
    if (sync_reset) begin
      shadow   <= '{fft_size: DEF_FFT_SIZE, avg_len: DEF_AVG_LEN};
      fft_size <= DEF_FFT_SIZE;
      avg_len  <= DEF_AVG_LEN;
    end else begin
      if (cfg_acc) shadow <= '{fft_size: bus.cfg_fft_size, avg_len: bus.cfg_avg_len};
      if (state == ST_DRAIN && drained) begin
        fft_size <= shadow.fft_size;
        avg_len  <= shadow.avg_len;
      end
    end
  end

  // in_frame is consumed inside the tracker's look-ahead; keep it visible for debug
  logic unused_in_frame;
  assign unused_in_frame = in_frame;

endmodule

// File: tb/tb_chan_cfg_sequencer.sv
// Directed bench for chan_cfg_sequencer: stimulus pushes expected sequence events,
// a monitor pops and compares them when the DUT completes a sequence or pulses cfg_err.
module tb_chan_cfg_sequencer;

  localparam int RSTC = 4;
  localparam int SETC = 24;
  localparam int EV_SEQ = 1;
  localparam int EV_ERR = 2;

  typedef struct {
    int kind;
    int a;      // SEQ: dp_reset length   ERR: pulse width
    int b;      // SEQ: settle length     ERR: busy at end of pulse
    int fft;
    int avg;
  } ev_t;

  logic        clk = 1'b0;
  logic        sync_reset;
  logic [11:0] fft_size;
  logic [8:0]  avg_len;
  logic        dp_reset, busy, cfg_err;

  chan_cfg_sequencer_if bus ();

  chan_cfg_sequencer #(
    .DEF_FFT_SIZE  (12'd256),
    .DEF_AVG_LEN   (9'd16),
    .RST_CYCLES    (RSTC),
    .SETTLE_CYCLES (SETC)
  ) dut (
    .clk        (clk),
    .sync_reset (sync_reset),
    .bus        (bus),
    .fft_size   (fft_size),
    .avg_len    (avg_len),
    .dp_reset   (dp_reset),
    .busy       (busy),
    .cfg_err    (cfg_err)
  );

  always #5 clk = ~clk;

  int  n_tests = 0;
  int  n_fail  = 0;
  ev_t exp_q[$];

  task automatic chk(input string name, input int act, input int exp);
    n_tests++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0d, expected %0d", name, act, exp);
    end
  endtask

  // ---------------- monitor / scoreboard ----------------
  int mon_ph = 0, mon_rl = 0, mon_sl = 0, mon_el = 0;

  task automatic pop_and_check(input int kind, input int a, input int b);
    ev_t e;
    if (exp_q.size() == 0) begin
      n_tests++;
      n_fail++;
      $display("FAIL unexpected_event: got kind %0d, expected none", kind);
    end else begin
      e = exp_q.pop_front();
      chk("ev_kind", kind, e.kind);
      chk(kind == EV_SEQ ? "seq_rst_len" : "err_width", a, e.a);
      chk(kind == EV_SEQ ? "seq_settle_len" : "err_busy", b, e.b);
      chk("ev_fft_size", int'(fft_size), e.fft);
      chk("ev_avg_len", int'(avg_len), e.avg);
    end
  endtask

  initial begin
    forever begin
      @(negedge clk);
      if (sync_reset) begin
        mon_ph = 0;
        mon_el = 0;
      end else begin
        case (mon_ph)
          0: if (dp_reset) begin mon_ph = 1; mon_rl = 1; end
          1: if (dp_reset) mon_rl++;
             else begin mon_ph = 2; mon_sl = busy ? 1 : 0; end
          default: if (busy) mon_sl++;
                   else begin pop_and_check(EV_SEQ, mon_rl, mon_sl); mon_ph = 0; end
        endcase
        if (cfg_err) mon_el++;
        else if (mon_el != 0) begin
          pop_and_check(EV_ERR, mon_el, int'(busy));
          mon_el = 0;
        end
      end
    end
  end

  // ---------------- stimulus helpers ----------------
  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic send_cfg(input int f, input int a);
    bus.cfg_valid    = 1'b1;
    bus.cfg_fft_size = f[11:0];
    bus.cfg_avg_len  = a[8:0];
    tick();
    bus.cfg_valid    = 1'b0;
  endtask

  task automatic dn_pulse();
    tick();
    bus.dn_tvalid = 1'b1; bus.dn_tready = 1'b1; bus.dn_tlast = 1'b1;
    tick();
    bus.dn_tvalid = 1'b0; bus.dn_tready = 1'b0; bus.dn_tlast = 1'b0;
  endtask

  task automatic wait_idle(input string name, input int max_cyc);
    bit done = 0;
    for (int i = 0; i < max_cyc && !done; i++) begin
      @(negedge clk);
      if (!busy) done = 1;
    end
    chk(name, int'(done), 1);
  endtask

  // watchdog
  initial begin
    #200us;
    $display("FAIL watchdog: got timeout, expected completion");
    n_fail++;
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $fatal(1, "watchdog");
  end

  // ---------------- stimulus ----------------
  int beat, busy_beats;
  bit cfg_sent, seen, saw_busy;

  initial begin
    sync_reset = 1'b1;
    bus.cfg_valid = 1'b0; bus.cfg_fft_size = '0; bus.cfg_avg_len = '0;
    bus.up_tvalid = 1'b0; bus.up_tlast = 1'b0; bus.dp_tready = 1'b0;
    bus.dn_tvalid = 1'b0; bus.dn_tready = 1'b0; bus.dn_tlast = 1'b0;
    repeat (3) @(posedge clk);
    #1 sync_reset = 1'b0;

    // reset state
    @(negedge clk);
    chk("rst_fft_size", int'(fft_size), 256);
    chk("rst_avg_len", int'(avg_len), 16);
    chk("rst_dp_reset", int'(dp_reset), 0);
    chk("rst_busy", int'(busy), 0);
    chk("rst_cfg_err", int'(cfg_err), 0);
    chk("rst_cfg_ready", int'(bus.cfg_ready), 1);

    // RUN passthrough in both directions
    tick(); bus.up_tvalid = 1'b1; bus.dp_tready = 1'b0;
    @(negedge clk);
    chk("run_dp_tvalid_hi", int'(bus.dp_tvalid), 1);
    chk("run_up_tready_lo", int'(bus.up_tready), 0);
    tick(); bus.up_tvalid = 1'b0; bus.dp_tready = 1'b1;
    @(negedge clk);
    chk("run_dp_tvalid_lo", int'(bus.dp_tvalid), 0);
    chk("run_up_tready_hi", int'(bus.up_tready), 1);

    // stray output tlast with nothing outstanding: counter must stay at 0
    dn_pulse();

    // idle stream, cfg (512,32)
    exp_q.push_back('{kind: EV_SEQ, a: RSTC, b: SETC, fft: 512, avg: 32});
    send_cfg(512, 32);
    @(negedge clk);
    chk("idle_drain_busy", int'(busy), 1);
    chk("idle_drain_cfg_ready", int'(bus.cfg_ready), 0);
    chk("idle_drain_fft_hold", int'(fft_size), 256);
    chk("idle_drain_dp_reset", int'(dp_reset), 0);
    @(negedge clk);
    chk("idle_reset_dp_reset", int'(dp_reset), 1);
    chk("idle_reset_fft", int'(fft_size), 512);
    wait_idle("idle_seq_done", 100);

    // cfg at beat 100 of a 256-beat frame
    exp_q.push_back('{kind: EV_SEQ, a: RSTC, b: SETC, fft: 1024, avg: 8});
    beat = 0; busy_beats = 0; cfg_sent = 0;
    for (int c = 0; c < 600 && beat < 256; c++) begin
      tick();
      bus.up_tvalid    = 1'b1;
      bus.up_tlast     = (beat == 255);
      bus.cfg_valid    = (beat == 100) && !cfg_sent;
      bus.cfg_fft_size = 12'd1024;
      bus.cfg_avg_len  = 9'd8;
      @(negedge clk);
      if (bus.cfg_valid && bus.cfg_ready) cfg_sent = 1;
      if (bus.up_tvalid && bus.up_tready) begin
        if (busy) busy_beats++;
        beat++;
      end
    end
    tick();
    bus.up_tlast = 1'b0; bus.cfg_valid = 1'b0;
    @(negedge clk);
    chk("frame_cfg_accepted", int'(cfg_sent), 1);
    chk("frame_beats_total", beat, 256);
    chk("frame_beats_after_cfg", busy_beats, 155);
    chk("frame_up_tready_after_eof", int'(bus.up_tready), 0);
    chk("frame_dp_tvalid_after_eof", int'(bus.dp_tvalid), 0);
    tick(); bus.up_tvalid = 1'b0;
    repeat (5) @(negedge clk);
    chk("frame_drain_wait_busy", int'(busy), 1);
    chk("frame_drain_wait_dp_reset", int'(dp_reset), 0);
    chk("frame_drain_wait_fft", int'(fft_size), 512);
    dn_pulse();
    wait_idle("frame_seq_done", 100);

    // three frames in, one output tlast coincident with the second: two outstanding
    tick(); bus.up_tvalid = 1'b1; bus.up_tlast = 1'b1;
    tick(); bus.dn_tvalid = 1'b1; bus.dn_tready = 1'b1; bus.dn_tlast = 1'b1;
    tick(); bus.dn_tvalid = 1'b0; bus.dn_tready = 1'b0; bus.dn_tlast = 1'b0;
    tick(); bus.up_tvalid = 1'b0; bus.up_tlast = 1'b0;
    exp_q.push_back('{kind: EV_SEQ, a: RSTC, b: SETC, fft: 128, avg: 4});
    send_cfg(128, 4);
    repeat (5) @(negedge clk);
    chk("two_out_wait_dp_reset", int'(dp_reset), 0);
    chk("two_out_wait_fft", int'(fft_size), 1024);
    // output tlast without tready does not count
    tick(); bus.dn_tvalid = 1'b1; bus.dn_tlast = 1'b1;
    tick(); bus.dn_tvalid = 1'b0; bus.dn_tlast = 1'b0;
    dn_pulse();
    @(negedge clk);
    chk("two_out_after_first_dp_reset", int'(dp_reset), 0);
    chk("two_out_after_first_fft", int'(fft_size), 1024);
    tick(); bus.dn_tvalid = 1'b1; bus.dn_tready = 1'b1; bus.dn_tlast = 1'b1;
    @(negedge clk);
    chk("two_out_second_cycle_fft", int'(fft_size), 1024);
    tick(); bus.dn_tvalid = 1'b0; bus.dn_tready = 1'b0; bus.dn_tlast = 1'b0;
    @(negedge clk);
    chk("two_out_dp_reset_rise", int'(dp_reset), 1);
    chk("two_out_fft_new", int'(fft_size), 128);
    wait_idle("two_out_seq_done", 100);

    // sync_reset during RESET aborts the sequence
    send_cfg(2048, 64);
    seen = 0;
    for (int i = 0; i < 20 && !seen; i++) begin
      @(negedge clk);
      if (dp_reset) seen = 1;
    end
    chk("abort_reached_reset", int'(seen), 1);
    tick(); sync_reset = 1'b1;
    tick(); sync_reset = 1'b0;
    @(negedge clk);
    chk("abort_dp_reset", int'(dp_reset), 0);
    chk("abort_fft", int'(fft_size), 256);
    chk("abort_avg", int'(avg_len), 16);
    saw_busy = 0;
    repeat (40) begin
      @(negedge clk);
      if (busy) saw_busy = 1;
    end
    chk("abort_no_resume", int'(saw_busy), 0);
    chk("abort_fft_stays", int'(fft_size), 256);

    // illegal fft_size 300
`ifdef CHAN_CFG_SEQUENCER_VALIDATE_EN
    exp_q.push_back('{kind: EV_ERR, a: 1, b: 0, fft: 256, avg: 16});
    send_cfg(300, 16);
    @(negedge clk);
    chk("bad_cfg_busy", int'(busy), 0);
    chk("bad_cfg_ready", int'(bus.cfg_ready), 1);
    repeat (3) @(negedge clk);
    chk("bad_cfg_fft", int'(fft_size), 256);
`else
    exp_q.push_back('{kind: EV_SEQ, a: RSTC, b: SETC, fft: 300, avg: 16});
    send_cfg(300, 16);
    wait_idle("any_cfg_seq_done", 100);
    chk("any_cfg_err", int'(cfg_err), 0);
`endif

    repeat (5) @(negedge clk);
    chk("scoreboard_empty", exp_q.size(), 0);
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule

// File: doc/chan_cfg_sequencer.md
CHAN_CFG_SEQUENCER -- requirements
Module: chan_cfg_sequencer

Interface
REQ-001 SHALL have parameter DEF_FFT_SIZE, default 12'd256: fft_size value after reset.
REQ-002 SHALL have parameter DEF_AVG_LEN, default 9'd16: avg_len value after reset.
REQ-003 SHALL have parameter RST_CYCLES, default 4: dp_reset pulse length in cycles (1..15).
REQ-004 SHALL have parameter SETTLE_CYCLES, default 24: idle cycles after dp_reset before traffic resumes (1..63).
REQ-005 SHALL have port clk, input, 1: the single clock.
REQ-006 SHALL have port sync_reset, input, 1: synchronous, active-high reset.
REQ-007 SHALL have port cfg_valid, input, 1: new configuration offered.
REQ-008 SHALL have port cfg_fft_size, input, 12: requested FFT size.
REQ-009 SHALL have port cfg_avg_len, input, 9: requested exponent-averaging length.
REQ-010 SHALL have port cfg_ready, output, 1: configuration accepted when high together with cfg_valid.
REQ-011 SHALL have ports up_tvalid/up_tlast (input, 1) and up_tready (output, 1): upstream stream into the datapath.
REQ-012 SHALL have ports dp_tvalid (output, 1) and dp_tready (input, 1): gated stream to the datapath.
REQ-013 SHALL have ports dn_tvalid/dn_tready/dn_tlast (input, 1 each): datapath output handshake, monitored only.
REQ-014 SHALL have outputs fft_size (12), avg_len (9), dp_reset (1), busy (1), cfg_err (1).

Function
REQ-015 SHALL implement states RUN, WAIT_EOF, DRAIN, RESET, SETTLE.
REQ-016 In RUN, SHALL drive dp_tvalid=up_tvalid and up_tready=dp_tready; in all other states, SHALL drive both low, except in WAIT_EOF as REQ-019.
REQ-017 SHALL assert cfg_ready only in RUN; an accepted cfg SHALL latch into shadow registers in the same cycle.
REQ-018 On accept, SHALL go to WAIT_EOF if a frame is partially transferred (in_frame=1), otherwise directly to DRAIN.
REQ-019 In WAIT_EOF, SHALL keep passing data until the handshake with up_tlast=1, then enter DRAIN on the next cycle.
REQ-020 SHALL keep a 4-bit outstanding-frame counter: +1 on accepted input tlast, -1 on dn_tvalid&dn_tready&dn_tlast; simultaneous events SHALL hold the value; the counter SHALL saturate at 15 and at 0.
REQ-021 In DRAIN, SHALL wait until the counter is 0, then copy the shadow registers to fft_size/avg_len and enter RESET on the same edge.
REQ-022 In RESET, SHALL hold dp_reset high for exactly RST_CYCLES cycles, then enter SETTLE.
REQ-023 In SETTLE, SHALL wait SETTLE_CYCLES cycles, then return to RUN.
REQ-024 SHALL drive busy high in every state except RUN.
REQ-025 fft_size and avg_len SHALL change only on the DRAIN->RESET edge.
REQ-026 SHALL set in_frame on an accepted beat with tlast=0 and clear it on an accepted beat with tlast=1.

Reset
REQ-027 On sync_reset, SHALL enter RUN and set fft_size=DEF_FFT_SIZE, avg_len=DEF_AVG_LEN, dp_reset=0, busy=0, cfg_err=0, counter=0, in_frame=0.
REQ-028 sync_reset asserted in any state SHALL abort the sequence and discard any pending shadow configuration.

Configuration
REQ-029 With CHAN_CFG_SEQUENCER_VALIDATE_EN defined, SHALL reject an accepted cfg unless fft_size is a power of two in 8..2048 and avg_len is nonzero: pulse cfg_err for 1 cycle and stay in RUN.
REQ-030 Without CHAN_CFG_SEQUENCER_VALIDATE_EN, SHALL accept every cfg and tie cfg_err to 0.

Structure
REQ-031 SHALL take the state enumeration, the defaults and the counter width from the shared package chan_cfg_pkg.
REQ-032 SHALL contain one sub-module, chan_cfg_frame_tracker, holding in_frame and the outstanding-frame counter.

Verification
REQ-033 Idle stream, cfg (512,32) -> DRAIN, then RESET with dp_reset high for 4 cycles, SETTLE for 24 cycles, RUN; fft_size=512 and avg_len=32.
REQ-034 cfg accepted at beat 100 of a 256-beat frame -> beats 101..255 pass; up_tready low from the cycle after tlast.
REQ-035 Two frames outstanding -> fft_size holds its old value until the second dn_tlast; dp_reset rises on the next edge.
REQ-036 Input tlast and output tlast in the same cycle -> counter unchanged.
REQ-037 sync_reset asserted during RESET -> dp_reset low next cycle and fft_size=256.
REQ-038 VALIDATE_EN build with cfg (300,16) -> cfg_err pulses for 1 cycle, state stays RUN, fft_size unchanged.
